control_sequencer: RTL and testbench

//  Microcoded control unit for the 8-bit bus CPU. It steps each instruction through

---
 rtl/control_sequencer.sv | 138 +++++++++++++
 tb/tb_control_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit bus CPU: steps fetch/execute states and drives the control word.
// Optional EARLY_STEP_RESET_EN: skip trailing empty T-states so short instructions finish early.
module control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [3:0]        instr,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              halted
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  // Microcode ROM: control word for a given opcode, T-state and flag state.
  function automatic logic [15:0] decode(input logic [3:0] op, input logic [STEP_W-1:0] t,
                                         input logic cf, input logic zf);
    logic [15:0] w;
    w = '0;
    case (int'(t))
      0: w = C_CO | C_MI;
      1: w = C_RO | C_II | C_CE;
      2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IO | C_MI;
          OP_LDI: w = C_IO | C_AI;
          OP_JMP: w = C_IO | C_J;
          OP_JC:  w = cf ? (C_IO | C_J) : '0;
          OP_JZ:  w = zf ? (C_IO | C_J) : '0;
          OP_OUT: w = C_AO | C_OI;
          OP_HLT: w = C_HLT;
          default: w = '0;
        endcase
      end
      3: begin
        case (op)
          OP_LDA:         w = C_RO | C_AI;
          OP_ADD, OP_SUB: w = C_RO | C_BI;
          OP_STA:         w = C_AO | C_RI;
          default:        w = '0;
        endcase
      end
      4: begin
        case (op)
          OP_ADD:  w = C_EO | C_AI | C_FI;
          OP_SUB:  w = C_EO | C_AI | C_SU | C_FI;
          default: w = '0;
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  logic [15:0]       word;
  logic [STEP_W-1:0] step_inc;
  logic [STEP_W-1:0] step_nxt;

  assign word     = decode(instr, step, carry_flag, zero_flag);
  assign step_inc = step + 1'b1;

  always_comb begin
    ctrl = '0;
    if (!rst && run) begin
      ctrl = halted ? C_HLT : word;
    end
  end

  always_comb begin
    step_nxt = (step == LAST_STEP) ? '0 : step_inc;
`ifdef EARLY_STEP_RESET_EN
    // Retire as soon as the remaining microcode is empty.
    if (step != '0 && step != LAST_STEP &&
        decode(instr, step_inc, carry_flag, zero_flag) == '0) begin
      step_nxt = '0;
    end
`endif
  end

  // The HLT edge latches halted and leaves step parked on the HLT T-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step       <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      halted     <= 1'b0;
    end else if (run && !halted) begin
      if (word[15]) begin
        halted <= 1'b1;
      end else begin
        step <= step_nxt;
      end
      if (word[0]) begin
        carry_flag <= alu_overflow;
        zero_flag  <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected outputs, a monitor compares each cycle.
// Expectations follow the build: trailing empty T-states are only expected without EARLY_STEP_RESET_EN.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  instr = 4'h0;
  logic        alu_overflow = 1'b0;
  logic        alu_zero = 1'b0;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        carry_flag;
  logic        zero_flag;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        cf;
    logic        zf;
    logic        h;
    string       tag;
  } exp_t;

  exp_t sb[$];

  control_sequencer #(.NUM_STEPS(5), .STEP_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .instr(instr),
    .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .ctrl(ctrl),
    .step(step),
    .carry_flag(carry_flag),
    .zero_flag(zero_flag),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Drive one cycle just after the active edge and queue what the DUT must show in it.
  task automatic cy(input logic r, input logic ru, input logic [3:0] op, input logic ov,
                    input logic zr, input logic [15:0] ec, input logic [2:0] es,
                    input logic ecf, input logic ezf, input logic eh, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    run = ru;
    instr = op;
    alu_overflow = ov;
    alu_zero = zr;
    e.ctrl = ec;
    e.step = es;
    e.cf = ecf;
    e.zf = ezf;
    e.h = eh;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Empty trailing T-states of a full-length instruction.
  task automatic idle(input logic [3:0] op, input logic cf, input logic zf, input int from);
    for (int s = from; s < 5; s++) begin
      cy(1'b0, 1'b1, op, 1'b0, 1'b0, 16'h0000, 3'(s), cf, zf, 1'b0, "empty_tstate");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (ctrl !== e.ctrl || step !== e.step || carry_flag !== e.cf ||
            zero_flag !== e.zf || halted !== e.h) begin
          errors++;
          $display("FAIL %s: got ctrl=%h step=%0d c=%b z=%b h=%b, expected ctrl=%h step=%0d c=%b z=%b h=%b",
                   e.tag, ctrl, step, carry_flag, zero_flag, halted,
                   e.ctrl, e.step, e.cf, e.zf, e.h);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset held: ctrl forced low even with run=1.
    cy(1, 1, 4'h1, 0, 0, 16'h0000, 0, 0, 0, 0, "rst_hold");
    // LDA
    cy(0, 1, 4'h1, 0, 0, 16'h4004, 0, 0, 0, 0, "lda_t0");
    cy(0, 1, 4'h1, 0, 0, 16'h1408, 1, 0, 0, 0, "lda_t1");
    cy(0, 1, 4'h1, 0, 0, 16'h4800, 2, 0, 0, 0, "lda_t2");
    cy(0, 1, 4'h1, 0, 0, 16'h1200, 3, 0, 0, 0, "lda_t3");
`ifndef EARLY_STEP_RESET_EN
    cy(0, 1, 4'h1, 0, 0, 16'h0000, 4, 0, 0, 0, "lda_t4");
`endif
    // SUB sets carry=1, zero=0
    cy(0, 1, 4'h3, 0, 0, 16'h4004, 0, 0, 0, 0, "sub_t0_wrap");
    cy(0, 1, 4'h3, 0, 0, 16'h1408, 1, 0, 0, 0, "sub_t1");
    cy(0, 1, 4'h3, 0, 0, 16'h4800, 2, 0, 0, 0, "sub_t2");
    cy(0, 1, 4'h3, 0, 0, 16'h1020, 3, 0, 0, 0, "sub_t3");
    cy(0, 1, 4'h3, 1, 0, 16'h02C1, 4, 0, 0, 0, "sub_t4");
    // JC taken
    cy(0, 1, 4'h7, 0, 0, 16'h4004, 0, 1, 0, 0, "sub_flags");
    cy(0, 1, 4'h7, 0, 0, 16'h1408, 1, 1, 0, 0, "jc_t1");
    cy(0, 1, 4'h7, 0, 0, 16'h0802, 2, 1, 0, 0, "jc_taken");
`ifndef EARLY_STEP_RESET_EN
    idle(4'h7, 1, 0, 3);
`endif
    // JZ not taken
    cy(0, 1, 4'h8, 0, 0, 16'h4004, 0, 1, 0, 0, "jz_t0");
    cy(0, 1, 4'h8, 0, 0, 16'h1408, 1, 1, 0, 0, "jz_t1");
`ifndef EARLY_STEP_RESET_EN
    cy(0, 1, 4'h8, 0, 0, 16'h0000, 2, 1, 0, 0, "jz_not_taken");
    idle(4'h8, 1, 0, 3);
`endif
    // ADD with a run=0 freeze at T3; ALU inputs wiggle while frozen
    cy(0, 1, 4'h2, 0, 0, 16'h4004, 0, 1, 0, 0, "add_t0");
    cy(0, 1, 4'h2, 0, 0, 16'h1408, 1, 1, 0, 0, "add_t1");
    cy(0, 1, 4'h2, 0, 0, 16'h4800, 2, 1, 0, 0, "add_t2");
    for (int i = 0; i < 4; i++) begin
      cy(0, 0, 4'h2, 1'(i), 1'(~i), 16'h0000, 3, 1, 0, 0, "add_frozen");
    end
    cy(0, 1, 4'h2, 0, 0, 16'h1020, 3, 1, 0, 0, "add_resume");
    cy(0, 1, 4'h2, 0, 1, 16'h0281, 4, 1, 0, 0, "add_t4");
    // JZ taken after ADD set zero
    cy(0, 1, 4'h8, 0, 0, 16'h4004, 0, 0, 1, 0, "add_flags");
    cy(0, 1, 4'h8, 0, 0, 16'h1408, 1, 0, 1, 0, "jz2_t1");
    cy(0, 1, 4'h8, 0, 0, 16'h0802, 2, 0, 1, 0, "jz_taken");
`ifndef EARLY_STEP_RESET_EN
    idle(4'h8, 0, 1, 3);
`endif
    // JC not taken
    cy(0, 1, 4'h7, 0, 0, 16'h4004, 0, 0, 1, 0, "jc2_t0");
    cy(0, 1, 4'h7, 0, 0, 16'h1408, 1, 0, 1, 0, "jc2_t1");
`ifndef EARLY_STEP_RESET_EN
    cy(0, 1, 4'h7, 0, 0, 16'h0000, 2, 0, 1, 0, "jc_not_taken");
    idle(4'h7, 0, 1, 3);
`endif
    // LDI
    cy(0, 1, 4'h5, 0, 0, 16'h4004, 0, 0, 1, 0, "ldi_t0");
    cy(0, 1, 4'h5, 0, 0, 16'h1408, 1, 0, 1, 0, "ldi_t1");
    cy(0, 1, 4'h5, 0, 0, 16'h0A00, 2, 0, 1, 0, "ldi_t2");
`ifndef EARLY_STEP_RESET_EN
    idle(4'h5, 0, 1, 3);
`endif
    // OUT
    cy(0, 1, 4'hE, 0, 0, 16'h4004, 0, 0, 1, 0, "out_t0");
    cy(0, 1, 4'hE, 0, 0, 16'h1408, 1, 0, 1, 0, "out_t1");
    cy(0, 1, 4'hE, 0, 0, 16'h0110, 2, 0, 1, 0, "out_t2");
`ifndef EARLY_STEP_RESET_EN
    idle(4'hE, 0, 1, 3);
`endif
    // HLT, then ten halted cycles with ALU inputs toggling
    cy(0, 1, 4'hF, 0, 0, 16'h4004, 0, 0, 1, 0, "hlt_t0");
    cy(0, 1, 4'hF, 0, 0, 16'h1408, 1, 0, 1, 0, "hlt_t1");
    cy(0, 1, 4'hF, 0, 0, 16'h8000, 2, 0, 1, 0, "hlt_t2");
    for (int i = 0; i < 10; i++) begin
      cy(0, 1, 4'hF, 1'(i), 1'(~i), 16'h8000, 2, 0, 1, 1, "halted");
    end
    // Reset clears halt; then reset aborts an LDA mid-instruction
    cy(1, 1, 4'hF, 0, 0, 16'h0000, 0, 0, 0, 0, "rst_from_halt");
    cy(0, 1, 4'h1, 0, 0, 16'h4004, 0, 0, 0, 0, "lda2_t0");
    cy(0, 1, 4'h1, 0, 0, 16'h1408, 1, 0, 0, 0, "lda2_t1");
    cy(0, 1, 4'h1, 0, 0, 16'h4800, 2, 0, 0, 0, "lda2_t2");
    cy(1, 1, 4'h1, 0, 0, 16'h0000, 0, 0, 0, 0, "rst_mid_lda");
    cy(0, 1, 4'h1, 0, 0, 16'h4004, 0, 0, 0, 0, "restart_t0");
    cy(0, 1, 4'h1, 0, 0, 16'h1408, 1, 0, 0, 0, "restart_t1");
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
